// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes, MIPS opcode/funct constants and decoded-control struct
// Compile-time option: ALU_DEC_ILLEGAL_TRAP_EN adds the illegal-encoding flag to alu_dec_t.
package alu_pkg;

    // ALU operation codes, shared with the execute-stage ALU
    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_AND     = 4'b0010;
    localparam logic [3:0] ALU_OR      = 4'b0011;
    localparam logic [3:0] ALU_SLL     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SRA     = 4'b0110;
    localparam logic [3:0] ALU_GREATER = 4'b0111;
    localparam logic [3:0] ALU_LESS    = 4'b1000;
    localparam logic [3:0] ALU_NOR     = 4'b1001;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [4:0]  shamt;
        logic        shift_var;
        logic        src_imm;
        logic [31:0] imm;
        logic        ovf_chk;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } alu_dec_t;

endpackage

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - combinational MIPS instruction to ALU control decode
// Ports: instr (32-bit instruction word) in; dec (alu_dec_t control bundle) out.
// Compile-time option: ALU_DEC_ILLEGAL_TRAP_EN flags unknown encodings instead of
// treating unknown I-type ops as an immediate ADD extended per IMM_SIGN_DEFAULT.
module alu_ctrl_decoder
    import alu_pkg::*;
#(
    parameter bit IMM_SIGN_DEFAULT = 1'b1
) (
    input  logic [31:0] instr,
    output alu_dec_t    dec
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        unused_rs_rt;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign sext         = {{16{instr[15]}}, instr[15:0]};
    assign zext         = {16'h0000, instr[15:0]};
    // Register specifiers are routed to the register file elsewhere
    assign unused_rs_rt = ^instr[25:16];

    always_comb begin
        dec          = '0;
        dec.alu_ctrl = ALU_ADD;
        // shamt is forwarded for every op; the ALU ignores it for non-shifts
        dec.shamt    = instr[10:6];

        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  begin dec.alu_ctrl = ALU_ADD; dec.ovf_chk = 1'b1; end
                FN_ADDU: dec.alu_ctrl = ALU_ADD;
                FN_SUB:  begin dec.alu_ctrl = ALU_SUB; dec.ovf_chk = 1'b1; end
                FN_SUBU: dec.alu_ctrl = ALU_SUB;
                FN_AND:  dec.alu_ctrl = ALU_AND;
                FN_OR:   dec.alu_ctrl = ALU_OR;
                FN_NOR:  dec.alu_ctrl = ALU_NOR;
                FN_SLT:  dec.alu_ctrl = ALU_LESS;
                FN_SLL:  dec.alu_ctrl = ALU_SLL;
                FN_SRL:  dec.alu_ctrl = ALU_SRL;
                FN_SRA:  dec.alu_ctrl = ALU_SRA;
                FN_SLLV: begin dec.alu_ctrl = ALU_SLL; dec.shift_var = 1'b1; end
                FN_SRLV: begin dec.alu_ctrl = ALU_SRL; dec.shift_var = 1'b1; end
                FN_SRAV: begin dec.alu_ctrl = ALU_SRA; dec.shift_var = 1'b1; end
                default: begin
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
                    dec.illegal = 1'b1;
`endif
                end
            endcase
        end else begin
            case (op)
                OP_ADDI:  begin dec.src_imm = 1'b1; dec.imm = sext; dec.ovf_chk = 1'b1; end
                OP_ADDIU: begin dec.src_imm = 1'b1; dec.imm = sext; end
                OP_SLTI:  begin dec.alu_ctrl = ALU_LESS; dec.src_imm = 1'b1; dec.imm = sext; end
                OP_ANDI:  begin dec.alu_ctrl = ALU_AND;  dec.src_imm = 1'b1; dec.imm = zext; end
                OP_ORI:   begin dec.alu_ctrl = ALU_OR;   dec.src_imm = 1'b1; dec.imm = zext; end
                OP_LW,
                OP_SW:    begin dec.src_imm = 1'b1; dec.imm = sext; end
                // Branch compare runs rs-rt; imm carries the sign-extended offset
                OP_BEQ,
                OP_BNE:   begin dec.alu_ctrl = ALU_SUB; dec.imm = sext; end
                // bgtz compares rs against zero, supplied as a zero immediate
                OP_BGTZ:  begin dec.alu_ctrl = ALU_GREATER; dec.src_imm = 1'b1; end
                default: begin
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
                    dec.illegal = 1'b1;
`else
                    dec.src_imm = 1'b1;
                    dec.imm     = IMM_SIGN_DEFAULT ? sext : zext;
`endif
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// rtl/alu_ctrl_decode_stage.sv - ID/EX register for decoded ALU controls with stall/flush
// Ports: clk, reset (async active-low); id_valid/id_instr decode input; stall, flush;
// ex_valid, ex_alu_ctrl, ex_shamt, ex_shift_var, ex_src_imm, ex_imm, ex_ovf_chk outputs,
// plus ex_illegal when ALU_DEC_ILLEGAL_TRAP_EN is defined.
module alu_ctrl_decode_stage
    import alu_pkg::*;
#(
    parameter bit IMM_SIGN_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_ctrl,
    output logic [4:0]  ex_shamt,
    output logic        ex_shift_var,
    output logic        ex_src_imm,
    output logic [31:0] ex_imm,
    output logic        ex_ovf_chk
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    ,
    output logic        ex_illegal
`endif
);

    alu_dec_t dec;
    alu_dec_t ex_q;
    logic     valid_q;

    alu_ctrl_decoder #(
        .IMM_SIGN_DEFAULT(IMM_SIGN_DEFAULT)
    ) u_decoder (
        .instr(id_instr),
        .dec  (dec)
    );

    // Fields load on every non-stalled edge even when id_valid is low;
    // flush only kills the valid (and illegal) bits, leaving fields stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
            ex_q.illegal <= 1'b0;
`endif
        end else if (!stall) begin
            valid_q <= id_valid;
            ex_q    <= dec;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
            ex_q.illegal <= dec.illegal & id_valid;
`endif
        end
    end

    assign ex_valid     = valid_q;
    assign ex_alu_ctrl  = ex_q.alu_ctrl;
    assign ex_shamt     = ex_q.shamt;
    assign ex_shift_var = ex_q.shift_var;
    assign ex_src_imm   = ex_q.src_imm;
    assign ex_imm       = ex_q.imm;
    assign ex_ovf_chk   = ex_q.ovf_chk;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    assign ex_illegal   = ex_q.illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// tb/tb_alu_ctrl_decode_stage.sv - self-checking bench for alu_ctrl_decode_stage
module tb_alu_ctrl_decode_stage;

    localparam bit IMM_SIGN_DEFAULT = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_shamt;
    logic        ex_shift_var;
    logic        ex_src_imm;
    logic [31:0] ex_imm;
    logic        ex_ovf_chk;
    logic        ill_bit;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    logic        ex_illegal;
    assign ill_bit = ex_illegal;
`else
    assign ill_bit = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    alu_ctrl_decode_stage #(.IMM_SIGN_DEFAULT(IMM_SIGN_DEFAULT)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .stall       (stall),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_alu_ctrl (ex_alu_ctrl),
        .ex_shamt    (ex_shamt),
        .ex_shift_var(ex_shift_var),
        .ex_src_imm  (ex_src_imm),
        .ex_imm      (ex_imm),
        .ex_ovf_chk  (ex_ovf_chk)
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        ,
        .ex_illegal  (ex_illegal)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: instruction semantics table, EX slot as plain variables
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  shamt;
        logic        sv;
        logic        si;
        logic [31:0] imm;
        logic        ovf;
        logic        ill;
    } dexp_t;

    logic  m_valid;
    logic  m_ill;
    logic  m_known;
    dexp_t m_f;

    function automatic dexp_t ref_decode(input logic [31:0] w);
        dexp_t d;
        int    op    = int'(w[31:26]);
        int    fn    = int'(w[5:0]);
        int    simm  = int'($signed(w[15:0]));
        int    zimm  = int'(w[15:0]);
        d       = '0;
        d.shamt = w[10:6];
        if (op == 0) begin
            case (fn)
                32, 33:  begin d.ctrl = 4'd0; d.ovf = (fn == 32); end
                34, 35:  begin d.ctrl = 4'd1; d.ovf = (fn == 34); end
                36:      d.ctrl = 4'd2;
                37:      d.ctrl = 4'd3;
                39:      d.ctrl = 4'd9;
                42:      d.ctrl = 4'd8;
                0, 4:    begin d.ctrl = 4'd4; d.sv = (fn == 4); end
                2, 6:    begin d.ctrl = 4'd5; d.sv = (fn == 6); end
                3, 7:    begin d.ctrl = 4'd6; d.sv = (fn == 7); end
                default: d.ill = 1'b1;
            endcase
        end else begin
            case (op)
                8, 9, 35, 43: begin d.si = 1; d.imm = simm; d.ovf = (op == 8); end
                10:      begin d.ctrl = 4'd8; d.si = 1; d.imm = simm; end
                12:      begin d.ctrl = 4'd2; d.si = 1; d.imm = zimm; end
                13:      begin d.ctrl = 4'd3; d.si = 1; d.imm = zimm; end
                4, 5:    begin d.ctrl = 4'd1; d.imm = simm; end
                7:       begin d.ctrl = 4'd7; d.si = 1; end
                default: begin
                    d.ill = 1'b1;
`ifndef ALU_DEC_ILLEGAL_TRAP_EN
                    d.si  = 1'b1;
                    d.imm = IMM_SIGN_DEFAULT ? simm : zimm;
`endif
                end
            endcase
        end
        return d;
    endfunction

    function automatic logic [45:0] obs_now();
        return {ex_valid, ex_alu_ctrl, ex_shamt, ex_shift_var, ex_src_imm,
                ex_imm, ex_ovf_chk, ill_bit};
    endfunction

    function automatic logic [45:0] exp_now();
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        return {m_valid, m_f.ctrl, m_f.shamt, m_f.sv, m_f.si, m_f.imm, m_f.ovf, m_ill};
`else
        return {m_valid, m_f.ctrl, m_f.shamt, m_f.sv, m_f.si, m_f.imm, m_f.ovf, 1'b0};
`endif
    endfunction

    // Fields are don't-care after a flush until the next load
    function automatic logic [45:0] exp_mask();
        return m_known ? {46{1'b1}} : {1'b1, 44'd0, 1'b1};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ill   = 1'b0;
        m_known = 1'b1;
        m_f     = '0;
    endtask

    // One rising edge; model follows the inputs present at the edge, sample #1 later
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else if (flush) begin
            m_valid = 1'b0;
            m_ill   = 1'b0;
            m_known = 1'b0;
        end else if (!stall) begin
            m_valid = id_valid;
            m_f     = ref_decode(id_instr);
            m_ill   = m_f.ill & id_valid;
            m_known = 1'b1;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_known();
        logic [5:0]  ops [11] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                                  6'h23, 6'h2B, 6'h04, 6'h05, 6'h07};
        logic [5:0]  fns [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                                  6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        logic [31:0] w = $urandom;
        w[31:26] = ops[$urandom_range(0, 10)];
        if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 13)];
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b0; id_valid = 1'b0; id_instr = '0; stall = 1'b0; flush = 1'b0;
        model_reset();
        #2;
        total++;
        if (obs_now() !== 46'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", obs_now());
        end
        tick();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add();
        id_valid = 1'b1; id_instr = 32'h012A4020;
        tick();
        total++;
        if ({ex_valid, ex_alu_ctrl, ex_ovf_chk, ex_src_imm} !== {1'b1, 4'b0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL add: got v=%b ctrl=%b ovf=%b si=%b want 1 0000 1 0",
                     ex_valid, ex_alu_ctrl, ex_ovf_chk, ex_src_imm);
        end
    endtask

    task automatic test_shift();
        id_instr = 32'h000A4843;
        tick();
        total++;
        if ({ex_alu_ctrl, ex_shamt, ex_shift_var} !== {4'b0110, 5'd1, 1'b0}) begin
            bad++;
            $display("FAIL sra: got ctrl=%b shamt=%0d sv=%b want 0110 1 0",
                     ex_alu_ctrl, ex_shamt, ex_shift_var);
        end
        id_instr = 32'h01494807;
        tick();
        total++;
        if ({ex_alu_ctrl, ex_shift_var} !== {4'b0110, 1'b1}) begin
            bad++;
            $display("FAIL srav: got ctrl=%b sv=%b want 0110 1", ex_alu_ctrl, ex_shift_var);
        end
    endtask

    task automatic test_imm_ext();
        id_instr = 32'h3128FFFF;
        tick();
        total++;
        if ({ex_alu_ctrl, ex_src_imm, ex_imm} !== {4'b0010, 1'b1, 32'h0000FFFF}) begin
            bad++;
            $display("FAIL andi: got ctrl=%b si=%b imm=%h want 0010 1 0000ffff",
                     ex_alu_ctrl, ex_src_imm, ex_imm);
        end
        id_instr = 32'h2128FFFF;
        tick();
        total++;
        if ({ex_alu_ctrl, ex_imm, ex_ovf_chk} !== {4'b0000, 32'hFFFFFFFF, 1'b1}) begin
            bad++;
            $display("FAIL addi: got ctrl=%b imm=%h ovf=%b want 0000 ffffffff 1",
                     ex_alu_ctrl, ex_imm, ex_ovf_chk);
        end
    endtask

    task automatic test_stall_flush();
        id_valid = 1'b1; id_instr = 32'h2128FFFF;
        tick();
        stall = 1'b1; id_instr = 32'h012A4025;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({ex_valid, ex_alu_ctrl, ex_src_imm, ex_imm, ex_ovf_chk} !==
                {1'b1, 4'b0000, 1'b1, 32'hFFFFFFFF, 1'b1}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got v=%b ctrl=%b si=%b imm=%h ovf=%b want addi",
                         i, ex_valid, ex_alu_ctrl, ex_src_imm, ex_imm, ex_ovf_chk);
            end
        end
        flush = 1'b1;
        tick();
        total++;
        if (ex_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_flush: got ex_valid=%b want 0", ex_valid);
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset_midstream();
        id_valid = 1'b1; id_instr = 32'h012A4020;
        tick();
        total++;
        if (ex_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_valid: got %b want 1", ex_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_now() !== 46'd0) begin
            bad++;
            $display("FAIL async_reset: got %h want 0", obs_now());
        end
        tick();
        @(negedge clk);
        reset = 1'b1;
        id_valid = 1'b1; id_instr = 32'h012A4020;
        tick();
        total++;
        if ({ex_valid, ex_alu_ctrl, ex_ovf_chk} !== {1'b1, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL post_reset_add: got v=%b ctrl=%b ovf=%b want 1 0000 1",
                     ex_valid, ex_alu_ctrl, ex_ovf_chk);
        end
    endtask

    task automatic test_unknown();
        id_valid = 1'b1; id_instr = 32'hFC000000;
        tick();
        total++;
        if ({ex_alu_ctrl, ex_ovf_chk, ex_shift_var, ex_imm} !== {4'b0000, 1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL unknown_op: got ctrl=%b ovf=%b sv=%b imm=%h want 0000 0 0 0",
                     ex_alu_ctrl, ex_ovf_chk, ex_shift_var, ex_imm);
        end
        total++;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        if ({ex_illegal, ex_src_imm} !== 2'b10) begin
            bad++;
            $display("FAIL unknown_op_flags: got ill=%b si=%b want 1 0", ex_illegal, ex_src_imm);
        end
`else
        if (ex_src_imm !== 1'b1) begin
            bad++;
            $display("FAIL unknown_op_flags: got si=%b want 1", ex_src_imm);
        end
`endif
        id_instr = 32'h3C00_8001;
        tick();
        total++;
        if (obs_now() !== exp_now()) begin
            bad++;
            $display("FAIL unknown_op_neg_imm: got %h want %h", obs_now(), exp_now());
        end
        id_instr = 32'h0000003F;
        tick();
        total++;
        if ({ex_alu_ctrl, ex_src_imm, ex_imm, ill_bit} !==
            {4'b0000, 1'b0, 32'd0, ill_bit_expected(1'b1)}) begin
            bad++;
            $display("FAIL unknown_funct: got ctrl=%b si=%b imm=%h ill=%b",
                     ex_alu_ctrl, ex_src_imm, ex_imm, ill_bit);
        end
        id_valid = 1'b0; id_instr = 32'hFC000000;
        tick();
        total++;
        if ({ex_valid, ill_bit} !== 2'b00) begin
            bad++;
            $display("FAIL unknown_invalid: got v=%b ill=%b want 0 0", ex_valid, ill_bit);
        end
    endtask

    function automatic logic ill_bit_expected(input logic unknown_valid);
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        return unknown_valid;
`else
        return 1'b0 & unknown_valid;
`endif
    endfunction

    task automatic test_back_to_back();
        stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            id_instr = rand_known();
            tick();
            total++;
            if (obs_now() !== exp_now()) begin
                bad++;
                $display("FAIL back_to_back[%0d] instr=%h: got %h want %h",
                         i, id_instr, obs_now(), exp_now());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            id_instr = ($urandom_range(0, 9) < 7) ? rand_known() : $urandom;
            tick();
            total++;
            if ((obs_now() & exp_mask()) !== (exp_now() & exp_mask())) begin
                bad++;
                $display("FAIL random[%0d] instr=%h st=%b fl=%b: got %h want %h",
                         i, id_instr, stall, flush, obs_now(), exp_now());
            end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_imm_ext();
        test_stall_flush();
        test_reset_midstream();
        test_unknown();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
